fetch_unit: RTL

//  Front end of the VLIW pipeline, directly upstream of the L1 instruction cache.

---
 rtl/vliw_pkg.sv | 26 ++
 rtl/fetch_buffer.sv | 56 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared types for the VLIW front end.
// Bundle width, physical address type and the fetch FSM encoding.
package vliw_pkg;
  localparam int NFU = 2;
  localparam int PHYSICAL_ADDRESS_LENGTH = 56;
  localparam int BUNDLE_BITS = NFU * 32;
  localparam int BUNDLE_BYTES = NFU * 4;
  localparam int LINE_OFFSET_BITS = $clog2(BUNDLE_BYTES);

  typedef logic [BUNDLE_BITS-1:0] bundle_t;
  typedef logic [PHYSICAL_ADDRESS_LENGTH-1:0] paddr_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    paddr_t  addr;
    bundle_t data;
  } fetch_entry_t;

  function automatic paddr_t align_pc(paddr_t a);
    return a & ~paddr_t'((1 << LINE_OFFSET_BITS) - 1);
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched bundles with their addresses.
// Pointers carry an extra MSB so full and empty are distinguishable.
module fetch_buffer
  import vliw_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic do_push, do_pop;

  assign count = wr_q - rd_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    do_pop  = pop & ~empty & ~flush;
    do_push = push & ~flush & (~full | do_pop);
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      rd_d = wr_q;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// VLIW fetch front end: owns the bundle PC, talks to the icache
// and queues returned bundles for decode.
module fetch_unit
  import vliw_pkg::*;
#(
  parameter int BUFFER_DEPTH = 4,
  parameter logic [PHYSICAL_ADDRESS_LENGTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               redirectValid,
  input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] redirectAddress,
  output logic [PHYSICAL_ADDRESS_LENGTH-1:0] fetchAddress,
  output logic                               doFetch,
  input  logic                               doneFetch,
  input  logic [BUNDLE_BITS-1:0]             fetchData,
  output logic                               bundleValid,
  input  logic                               bundleReady,
  output logic [BUNDLE_BITS-1:0]             bundleData,
  output logic [PHYSICAL_ADDRESS_LENGTH-1:0] bundleAddress
);
  localparam int AW = $clog2(BUFFER_DEPTH);

  fetch_state_e state_q, state_d;
  paddr_t pc_q, pc_d;
  paddr_t pend_addr_q, pend_addr_d;
  paddr_t redir_addr;
  logic armed_q, armed_d;
  logic pend_q, pend_d;
  logic accept, push, pop, load;
  logic full, empty;
  logic [AW:0] count;
  logic [AW+1:0] occ_next;
  fetch_entry_t wentry, head;

  assign doFetch       = (state_q == REQ);
  assign fetchAddress  = pc_q;
  assign accept        = doFetch & armed_q & doneFetch;
  assign push          = accept & ~pend_q & ~redirectValid;
  assign pop           = bundleReady & ~empty;
  assign wentry        = '{addr: pc_q, data: fetchData};
  assign bundleValid   = ~empty;
  assign bundleData    = head.data;
  assign bundleAddress = head.addr;

  fetch_buffer #(.DEPTH(BUFFER_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirectValid),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    redir_addr  = align_pc(redirectAddress);
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    load        = 1'b0;
    if (redirectValid) occ_next = '0;
    else occ_next = (AW+2)'(count) + (AW+2)'(push) - (AW+2)'(pop);
    // An in-flight miss is never abandoned; redirects wait for its accept.
    unique case (1'b1)
      accept & (redirectValid | pend_q): begin
        pc_d   = redirectValid ? redir_addr : pend_addr_q;
        pend_d = 1'b0;
        load   = 1'b1;
      end
      accept & ~redirectValid & ~pend_q: begin
        pc_d = pc_q + paddr_t'(BUNDLE_BYTES);
        load = 1'b1;
      end
      ~accept & redirectValid & doFetch: begin
        pend_d      = 1'b1;
        pend_addr_d = redir_addr;
      end
      ~accept & redirectValid & ~doFetch: begin
        pc_d = redir_addr;
        load = 1'b1;
      end
      default: ;
    endcase
    state_d = state_q;
    unique case (state_q)
      IDLE: if (~full | pop | redirectValid) state_d = REQ;
      REQ:  if (accept & (occ_next >= (AW+2)'(BUFFER_DEPTH))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    armed_d = doFetch & (state_d == REQ) & ~load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VECTOR;
      armed_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end
endmodule
